// File: rtl/lz77_pkg.sv
// Shared constants, types and FSM encoding for the LZ77 match encoder.
package lz77_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int LOOKAHEAD_SIZE = 6;
  localparam int SEARCH_SIZE    = 8;
  localparam int OFFSET_WIDTH   = 4;
  localparam int LEN_WIDTH      = 3;
  localparam int COUNT_WIDTH    = 3;
  localparam int HIST_WIDTH     = $clog2(SEARCH_SIZE + 1);
  localparam int IDX_WIDTH      = $clog2(SEARCH_SIZE);

  typedef logic [DATA_WIDTH-1:0]   sym_t;
  typedef logic [OFFSET_WIDTH-1:0] offset_t;
  typedef logic [LEN_WIDTH-1:0]    len_t;
  typedef logic [COUNT_WIDTH-1:0]  count_t;
  typedef logic [HIST_WIDTH-1:0]   hist_t;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    EMIT,
    SHIFT
  } state_t;

  // Token fields as seen by the packer and decoder.
  typedef struct packed {
    offset_t offset;
    len_t    length;
    sym_t    symbol;
  } token_t;

  // Upstream may report more valid bytes than the lookahead holds.
  function automatic count_t clampCount(input count_t c);
    return (int'(c) > LOOKAHEAD_SIZE) ? count_t'(LOOKAHEAD_SIZE) : c;
  endfunction

endpackage

// File: rtl/lz77_match_len.sv
// Match length of the lookahead against the window at one candidate offset.
module lz77_match_len
  import lz77_pkg::*;
(
  input  sym_t    i_look   [LOOKAHEAD_SIZE],
  input  sym_t    i_window [SEARCH_SIZE],
  input  offset_t i_offset,
  input  count_t  i_count,
  output len_t    o_length
);

  int                   w_limit;
  logic                 w_run;
  logic [IDX_WIDTH-1:0] w_idx;
  len_t                 w_len;

  // Count leading matches, capped so the match never reaches into the
  // lookahead and always leaves one byte for the literal that follows.
  always_comb begin
    w_limit = (int'(i_offset) < int'(i_count) - 1) ? int'(i_offset) : int'(i_count) - 1;
    w_run   = 1'b1;
    w_idx   = '0;
    w_len   = '0;
    for (int k = 0; k < LOOKAHEAD_SIZE - 1; k++) begin
      if (w_run && (k < w_limit)) begin
        w_idx = IDX_WIDTH'(int'(i_offset) - 1 - k);
        if (i_look[k] == i_window[w_idx]) begin
          w_len = w_len + 1'b1;
        end else begin
          w_run = 1'b0;
        end
      end
    end
  end

  assign o_length = w_len;

endmodule

// File: rtl/lz77_match_encoder.sv
// Sliding-window LZ77 match search with token handshake and window refill.
module lz77_match_encoder
  import lz77_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [LOOKAHEAD_SIZE*DATA_WIDTH-1:0] lookahead_in,
  input  logic [COUNT_WIDTH-1:0]               la_count,
  input  logic                                 start,
  input  logic                                 flush,
  output logic                                 token_valid,
  input  logic                                 token_ready,
  output logic [OFFSET_WIDTH-1:0]              token_offset,
  output logic [LEN_WIDTH-1:0]                 token_length,
  output logic [DATA_WIDTH-1:0]                token_char,
  output logic                                 consume,
  output logic                                 busy
);

  state_t  r_state;
  sym_t    r_look   [LOOKAHEAD_SIZE];
  sym_t    r_window [SEARCH_SIZE];
  count_t  r_count;
  hist_t   r_hist;
  offset_t r_offset;
  offset_t r_bestOffset;
  len_t    r_bestLength;
  token_t  r_token;
  len_t    r_shiftIdx;
  logic    r_tokenValid;
  logic    r_consume;
  logic    r_busy;

  len_t    w_candLength;
  logic    w_better;
  offset_t w_nextBestOffset;
  len_t    w_nextBestLength;

  lz77_match_len u_matchLen (
    .i_look   (r_look),
    .i_window (r_window),
    .i_offset (r_offset),
    .i_count  (r_count),
    .o_length (w_candLength)
  );

  // Offsets reaching past the real history never count; strict compare keeps the nearest on ties.
  always_comb begin
    w_better         = (int'(r_offset) <= int'(r_hist)) && (w_candLength > r_bestLength);
    w_nextBestOffset = w_better ? r_offset : r_bestOffset;
    w_nextBestLength = w_better ? w_candLength : r_bestLength;
  end

  // Main FSM: snapshot, scan every offset, present token, then refill the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      for (int i = 0; i < LOOKAHEAD_SIZE; i++) r_look[i] <= '0;
      for (int i = 0; i < SEARCH_SIZE; i++) r_window[i] <= '0;
      r_count      <= '0;
      r_hist       <= '0;
      r_offset     <= '0;
      r_bestOffset <= '0;
      r_bestLength <= '0;
      r_token      <= '0;
      r_shiftIdx   <= '0;
      r_tokenValid <= 1'b0;
      r_consume    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) begin
            for (int i = 0; i < SEARCH_SIZE; i++) r_window[i] <= '0;
            r_hist <= '0;
          end else if (start && (la_count != '0)) begin
            for (int k = 0; k < LOOKAHEAD_SIZE; k++) begin
              r_look[k] <= lookahead_in[(LOOKAHEAD_SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH];
            end
            r_count      <= clampCount(la_count);
            r_offset     <= offset_t'(1);
            r_bestOffset <= '0;
            r_bestLength <= '0;
            r_busy       <= 1'b1;
            r_state      <= SEARCH;
          end
        end

        SEARCH: begin
          r_bestOffset <= w_nextBestOffset;
          r_bestLength <= w_nextBestLength;
          if (r_offset == offset_t'(SEARCH_SIZE)) begin
            r_token.offset <= (w_nextBestLength == '0) ? '0 : w_nextBestOffset;
            r_token.length <= w_nextBestLength;
            r_token.symbol <= r_look[w_nextBestLength];
            r_tokenValid   <= 1'b1;
            r_state        <= EMIT;
          end else begin
            r_offset <= r_offset + 1'b1;
          end
        end

        EMIT: begin
          if (token_ready) begin
            r_tokenValid <= 1'b0;
            r_shiftIdx   <= '0;
            r_consume    <= 1'b1;
            r_state      <= SHIFT;
          end
        end

        SHIFT: begin
          for (int i = SEARCH_SIZE - 1; i > 0; i--) r_window[i] <= r_window[i-1];
          r_window[0] <= r_look[r_shiftIdx];
          if (r_hist != hist_t'(SEARCH_SIZE)) r_hist <= r_hist + 1'b1;
          if (r_shiftIdx == r_token.length) begin
            r_consume <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_shiftIdx <= r_shiftIdx + 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign token_valid  = r_tokenValid;
  assign token_offset = r_token.offset;
  assign token_length = r_token.length;
  assign token_char   = r_token.symbol;
  assign consume      = r_consume;
  assign busy         = r_busy;

endmodule

// File: tb/tb_lz77_match_encoder.sv
// Randomized self-checking bench for lz77_match_encoder against a stream-level LZ77 model.
module tb_lz77_match_encoder;
  import lz77_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] lookahead_in;
  logic [2:0]  la_count;
  logic        start;
  logic        flush;
  logic        token_valid;
  logic        token_ready;
  logic [3:0]  token_offset;
  logic [2:0]  token_length;
  logic [7:0]  token_char;
  logic        consume;
  logic        busy;

  int testCount = 0;
  int failCount = 0;

  // Every byte encoded since the last flush, oldest first.
  logic [7:0] stream[$];

  lz77_match_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .lookahead_in (lookahead_in),
    .la_count     (la_count),
    .start        (start),
    .flush        (flush),
    .token_valid  (token_valid),
    .token_ready  (token_ready),
    .token_offset (token_offset),
    .token_length (token_length),
    .token_char   (token_char),
    .consume      (consume),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [47:0] packLa(input string s);
    logic [47:0] v;
    v = '0;
    for (int k = 0; k < s.len() && k < 6; k++) v[(5-k)*8 +: 8] = s[k];
    return v;
  endfunction

  // Longest earlier occurrence within the last SEARCH_SIZE bytes, nearest wins ties.
  task automatic modelToken(input logic [47:0] laVec, input int n,
                            output int off, output int len, output int ch);
    logic [7:0] la[6];
    int avail;
    int l;
    for (int k = 0; k < 6; k++) la[k] = laVec[(5-k)*8 +: 8];
    off = 0;
    len = 0;
    avail = (stream.size() < SEARCH_SIZE) ? stream.size() : SEARCH_SIZE;
    for (int o = 1; o <= avail; o++) begin
      l = 0;
      while (l < o && l < n - 1 && stream[stream.size() - o + l] == la[l]) l++;
      if (l > len) begin
        len = l;
        off = o;
      end
    end
    ch = la[len];
  endtask

  task automatic doFlush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    stream.delete();
  endtask

  // One full transaction: start, wait for token, hold, accept, count consumes.
  task automatic applyStimulus(input logic [47:0] laVec, input int laCount, input int readyDelay,
                               output int gotOff, output int gotLen, output int gotChar);
    int n, eOff, eLen, eCh, cyc, pulses;
    n = (laCount > 6) ? 6 : laCount;
    modelToken(laVec, n, eOff, eLen, eCh);
    gotOff = -1;
    gotLen = -1;
    gotChar = -1;
    lookahead_in = laVec;
    la_count = 3'(laCount);
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end while (!token_valid && cyc < 40);
    checkOutput("latency", cyc, SEARCH_SIZE + 1);
    if (!token_valid) return;
    checkOutput("offset", int'(token_offset), eOff);
    checkOutput("length", int'(token_length), eLen);
    checkOutput("char", int'(token_char), eCh);
    gotOff = int'(token_offset);
    gotLen = int'(token_length);
    gotChar = int'(token_char);
    for (int d = 0; d < readyDelay; d++) begin
      checkOutput("holdValid", int'(token_valid), 1);
      checkOutput("holdFields", int'({token_offset, token_length, token_char}),
                  (eOff << 11) | (eLen << 8) | eCh);
      checkOutput("holdConsume", int'(consume), 0);
      checkOutput("holdBusy", int'(busy), 1);
      @(posedge clk); #1;
    end
    token_ready = 1'b1;
    @(posedge clk); #1;
    token_ready = 1'b0;
    checkOutput("dropValid", int'(token_valid), 0);
    pulses = 0;
    cyc = 0;
    while (consume && cyc < 20) begin
      pulses++;
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("consumeCount", pulses, eLen + 1);
    checkOutput("idleBusy", int'(busy), 0);
    for (int k = 0; k <= eLen; k++) stream.push_back(laVec[(5-k)*8 +: 8]);
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "Valid"}, int'(token_valid), 0);
    checkOutput({tag, "Consume"}, int'(consume), 0);
    checkOutput({tag, "Busy"}, int'(busy), 0);
    checkOutput({tag, "Fields"}, int'({token_offset, token_length, token_char}), 0);
  endtask

  initial begin
    int o, l, c;
    logic [47:0] vec;
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    token_ready = 1'b0;
    lookahead_in = '0;
    la_count = '0;
    #2;
    checkZeroOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty history always yields a literal.
    applyStimulus(packLa("ABCABC"), 6, 0, o, l, c);
    checkOutput("emptyTok", (o << 16) | (l << 8) | c, (0 << 16) | (0 << 8) | 65);

    // Build history C,B,A (newest first) then find the full three-byte match.
    doFlush();
    applyStimulus(packLa("A"), 1, 0, o, l, c);
    applyStimulus(packLa("B"), 1, 0, o, l, c);
    applyStimulus(packLa("C"), 1, 0, o, l, c);
    applyStimulus(packLa("ABCD"), 4, 5, o, l, c);
    checkOutput("abcdTok", (o << 16) | (l << 8) | c, (3 << 16) | (3 << 8) | 68);

    // Equal-length matches at offsets 1 and 3 pick the nearer one.
    doFlush();
    applyStimulus(packLa("A"), 1, 0, o, l, c);
    applyStimulus(packLa("X"), 1, 0, o, l, c);
    applyStimulus(packLa("A"), 1, 0, o, l, c);
    applyStimulus(packLa("AZ"), 2, 1, o, l, c);
    checkOutput("tieTok", (o << 16) | (l << 8) | c, (1 << 16) | (1 << 8) | 90);

    // A single valid byte can only be a literal even if history matches.
    applyStimulus(packLa("ZZZZ"), 1, 0, o, l, c);
    checkOutput("oneByteTok", (o << 16) | (l << 8) | c, (0 << 16) | (0 << 8) | 90);

    // Start without any valid bytes is ignored.
    lookahead_in = packLa("AB");
    la_count = 3'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("zeroCountBusy", int'(busy), 0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a search discards everything.
    lookahead_in = packLa("ABCD");
    la_count = 3'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    checkZeroOutputs("midReset");
    @(posedge clk); #1;
    rst = 1'b0;
    stream.delete();
    applyStimulus(packLa("ABCD"), 4, 0, o, l, c);
    checkOutput("postResetTok", (o << 16) | (l << 8) | c, (0 << 16) | (0 << 8) | 65);

    // Flush wins over a simultaneous start.
    lookahead_in = packLa("AB");
    la_count = 3'd2;
    flush = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    start = 1'b0;
    stream.delete();
    for (int i = 0; i < 3; i++) begin
      checkOutput("flushStartBusy", int'(busy), 0);
      @(posedge clk); #1;
    end
    applyStimulus(packLa("AB"), 2, 0, o, l, c);
    checkOutput("postFlushTok", (o << 16) | (l << 8) | c, (0 << 16) | (0 << 8) | 65);

    // Random traffic over a small alphabet so matches are frequent.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0) doFlush();
      for (int k = 0; k < 6; k++) vec[(5-k)*8 +: 8] = 8'($urandom_range(65, 67));
      applyStimulus(vec, int'($urandom_range(1, 7)), int'($urandom_range(0, 3)), o, l, c);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
